// File: rtl/types.sv
// Shared line-state encoding for the low-speed USB receive path.
// Low speed: J = D- high, K = D+ high.
package types;

  typedef logic [1:0] d_port_t;

  localparam d_port_t LS_SE0 = 2'b00;
  localparam d_port_t LS_J   = 2'b01;
  localparam d_port_t LS_K   = 2'b10;
  localparam d_port_t LS_SE1 = 2'b11;

endpackage

// File: rtl/usb_rx_phy.sv
// Low-speed USB receive front end: sync, DPLL, NRZI decode, SYNC detect, destuff, byte assembly.
// Latency: pads to line_state 2 clk (4 clk with glitch filter); byte out ~9 clk after its last bit edge.
// Backpressure: none; rx_valid is a one-clk pulse the consumer must take when it appears.
//
// Ports:
//   clk, reset      24 MHz clock, asynchronous active-low reset
//   dp, dn          raw asynchronous D+/D- pads
//   rx_enable       0 forces IDLE (used while our own transmitter drives the bus)
//   line_state      synchronized {D+,D-}
//   rx_data/rx_valid  received byte and its one-clk strobe
//   rx_active       high from end of SYNC until the J following EOP
//   rx_error        one-clk pulse on stuff error, SE1, or partial byte at EOP
// Optional build macro USB_RX_GLITCH_FILTER_EN: line_state only follows 3 identical
// synchronized samples, suppressing pulses of 2 clk or less.
module usb_rx_phy #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SAMPLE_PHASE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dp,
  input  logic            dn,
  input  logic            rx_enable,
  output types::d_port_t  line_state,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  output logic            rx_active,
  output logic            rx_error
);
  import types::*;

  localparam int PW = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SYNC     = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_ERR_WAIT = 3'd3;
  localparam logic [2:0] ST_EOP      = 3'd4;

  // Two-flop synchronizer; both pads move together so they share stages.
  d_port_t sync1, sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= LS_J;
      sync2 <= LS_J;
    end else begin
      sync1 <= {dp, dn};
      sync2 <= sync1;
    end
  end

`ifdef USB_RX_GLITCH_FILTER_EN
  // Output follows the pads only once three consecutive synchronized samples
  // agree; otherwise the last accepted state is held.
  d_port_t hist1, hist2, held;
  logic    stable;

  assign stable     = (sync2 == hist1) && (hist1 == hist2);
  assign line_state = stable ? hist2 : held;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist1 <= LS_J;
      hist2 <= LS_J;
      held  <= LS_J;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
      held  <= line_state;
    end
  end
`else
  assign line_state = sync2;
`endif

  // DPLL: phase restarts on every J<->K edge so sampling lands mid-bit even
  // when the transmitter's bit period is off by one clock.
  d_port_t       ls_q;
  logic [PW-1:0] phase;
  logic          ls_is_jk, lsq_is_jk, jk_edge, sample;

  assign ls_is_jk  = (line_state == LS_J) || (line_state == LS_K);
  assign lsq_is_jk = (ls_q == LS_J) || (ls_q == LS_K);
  assign jk_edge   = ls_is_jk && lsq_is_jk && (line_state != ls_q);
  assign sample    = (phase == PW'(SAMPLE_PHASE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ls_q  <= LS_J;
      phase <= '0;
    end else begin
      ls_q <= line_state;
      if (jk_edge || phase == PW'(CLKS_PER_BIT - 1))
        phase <= '0;
      else
        phase <= phase + 1'b1;
    end
  end

  // Receive FSM.
  logic [2:0] state;
  d_port_t    prev_ls;
  logic [2:0] sync_cnt;
  logic [2:0] bit_cnt;
  logic [2:0] ones_cnt;
  logic [6:0] shreg;
  logic       nrzi_bit;

  // NRZI: no change between samples is a 1.
  assign nrzi_bit = (line_state == prev_ls);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      prev_ls   <= LS_J;
      sync_cnt  <= '0;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_active <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (!rx_enable) begin
        state     <= ST_IDLE;
        rx_active <= 1'b0;
      end else if (state == ST_IDLE) begin
        if (ls_q == LS_J && line_state == LS_K) begin
          state    <= ST_SYNC;
          prev_ls  <= LS_J;
          sync_cnt <= '0;
        end
      end else if (sample) begin
        if (line_state == LS_SE1) begin
          rx_error <= 1'b1;
          state    <= ST_ERR_WAIT;
        end else begin
          case (state)
            ST_SYNC: begin
              if (line_state == LS_SE0) begin
                state <= ST_IDLE;
              end else begin
                prev_ls <= line_state;
                if (!nrzi_bit) begin
                  if (sync_cnt == 3'd7) state <= ST_IDLE;
                  else                  sync_cnt <= sync_cnt + 3'd1;
                end else if (sync_cnt == 3'd7) begin
                  state     <= ST_DATA;
                  rx_active <= 1'b1;
                  bit_cnt   <= '0;
                  ones_cnt  <= '0;
                end else begin
                  state <= ST_IDLE;
                end
              end
            end
            ST_DATA: begin
              if (line_state == LS_SE0) begin
                state <= ST_EOP;
                if (bit_cnt != 3'd0) rx_error <= 1'b1;
              end else begin
                prev_ls <= line_state;
                if (ones_cnt == 3'd6) begin
                  // Bit after six 1s is a stuffed 0 and is dropped.
                  if (nrzi_bit) begin
                    rx_error <= 1'b1;
                    state    <= ST_ERR_WAIT;
                  end else begin
                    ones_cnt <= '0;
                  end
                end else begin
                  ones_cnt <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                  shreg    <= {nrzi_bit, shreg[6:1]};
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                    rx_data  <= {nrzi_bit, shreg};
                    rx_valid <= 1'b1;
                  end
                end
              end
            end
            ST_ERR_WAIT: begin
              if (line_state == LS_SE0) state <= ST_EOP;
            end
            ST_EOP: begin
              if (line_state == LS_J) begin
                rx_active <= 1'b0;
                state     <= ST_IDLE;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule
